axis_gap_source: RTL and testbench
==================================

AXIS_GAP_SOURCE -- requirements
Module: axis_gap_source

Interface
REQ-001 Parameter DATA_WIDTH, default 32, shall set the width of tdata and of the data counter.
REQ-002 Parameter MAX_GAP_CYCLES, default 10, shall set the maximum number of idle cycles inserted before each beat; 0 means back-to-back.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, shall set the LFSR reset value; it is nonzero by construction.
REQ-004 Parameter DATA_START, default 0, shall set the tdata value of the first beat of every burst.
REQ-005 clock_i  in  1  shall be the single clock; all logic is rising-edge.
REQ-006 reset_n_i  in  1  shall be the reset: asynchronous assert, active-low.
REQ-007 start_i  in  1  shall be a single-cycle burst request, sampled only in IDLE.
REQ-008 num_beats_i  in  32  shall give the burst length, sampled with start_i.
REQ-009 busy_o  out  1  shall be high in every state except IDLE.
REQ-010 done_o  out  1  shall be a one-cycle pulse marking burst completion.
REQ-011 beats_sent_o  out  32  shall count accepted beats in the current or last burst.
REQ-012 axis_m  axi_stream_simple_if.master  shall carry tvalid (out, 1), tready (in, 1) and tdata (out, DATA_WIDTH).

Function
REQ-013 The FSM shall have exactly four states, IDLE, GAP, SEND and DONE.
REQ-014 A gap draw shall compute gap = lfsr mod (MAX_GAP_CYCLES+1) from the current LFSR value and advance the LFSR one step in the same cycle.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11.
- The LFSR shall advance only on a draw, so gap sequences are deterministic per seed.
REQ-015 IDLE with start_i=1 and num_beats_i>0 shall:
- latch num_beats_i;
- clear beats_sent_o;
- load the data counter with DATA_START;
- perform a draw, going to GAP if gap>0, else to SEND.
REQ-016 IDLE with start_i=1 and num_beats_i=0 shall go to DONE with no beat issued.
REQ-017 GAP shall hold tvalid=0 for exactly gap cycles, then enter SEND.
REQ-018 SEND shall drive tvalid=1 and tdata=data counter.
REQ-019 While SEND and tready=0, tvalid and tdata shall hold stable, with no cycle limit.
REQ-020 On tvalid&tready, beats_sent_o and the data counter shall each increment by 1; the data counter wraps modulo 2^DATA_WIDTH.
REQ-021 After a handshake on the last beat (beats_sent_o reaches the latched count), the FSM shall go to DONE.
REQ-022 After a handshake on any other beat, the FSM shall perform a draw and go to GAP (gap>0) or stay in SEND (gap=0, back-to-back beats).
REQ-023 DONE shall assert done_o for one cycle, then return to IDLE.
REQ-024 start_i outside IDLE shall be ignored; changes to num_beats_i during a burst shall have no effect.
REQ-025 tvalid shall never depend combinationally on tready.
REQ-026 With a gap of 0 and tready=1, the first tvalid shall occur in the cycle after start_i.

Reset
REQ-027 reset_n_i=0 shall immediately force:
- state IDLE;
- tvalid=0, tdata=0, busy_o=0, done_o=0, beats_sent_o=0;
- lfsr=LFSR_SEED, data counter=DATA_START.
REQ-028 Reset asserted mid-burst shall abort the burst with no done_o pulse.
REQ-029 After reset deasserts, the first rising edge shall be treated as normal operation in IDLE.

Verification
REQ-030 The bench shall cover MAX_GAP_CYCLES=0, tready=1, start_i with num_beats_i=4 -> tvalid high for 4 consecutive cycles starting the cycle after start_i, tdata 0,1,2,3, then done_o for 1 cycle and beats_sent_o=4.
REQ-031 The bench shall cover default parameters, num_beats_i=100, tready randomly toggled -> tdata 0..99 in order with no loss or duplicate; the idle gap before each beat is in 0..10 and matches a reference LFSR model.
REQ-032 The bench shall cover tready held 0 for 50 cycles during SEND -> tvalid and tdata constant for all 50 cycles; the beat is accepted on the first tready=1.
REQ-033 The bench shall cover num_beats_i=0 -> no tvalid, busy_o high for 1 cycle, done_o one cycle later; a second start_i while busy is ignored.
REQ-034 The bench shall cover DATA_WIDTH=8, DATA_START=8'hFE, num_beats_i=3 -> tdata FE, FF, 00.
REQ-035 The bench shall cover reset_n_i pulsed low after beat 5 of 10 -> outputs at reset values immediately, no done_o; the next burst replays the identical gap sequence from LFSR_SEED.

Source files
------------

// File: rtl/axis_gap_source_if.sv
// Minimal AXI-Stream link: valid/ready handshake carrying one data word.
interface axi_stream_simple_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_gap_source.sv
// AXI-Stream burst source that inserts LFSR-driven idle gaps before each beat.
// A burst of num_beats_i beats carries an incrementing data counter starting at
// DATA_START. Before every beat a pseudo-random gap of 0..MAX_GAP_CYCLES idle
// cycles is drawn from a 16-bit Fibonacci LFSR (taps 16,14,13,11). The LFSR
// advances only on a draw, so the gap sequence is reproducible from LFSR_SEED.
module axis_gap_source #(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           MAX_GAP_CYCLES = 10,
    parameter logic [15:0]           LFSR_SEED      = 16'hACE1,
    parameter logic [DATA_WIDTH-1:0] DATA_START     = '0
) (
    input  logic                clock_i,
    input  logic                reset_n_i,
    input  logic                start_i,
    input  logic [31:0]         num_beats_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [31:0]         beats_sent_o,
    axi_stream_simple_if.master axis_m
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [15:0] GAP_MOD = 16'(MAX_GAP_CYCLES + 1);

    state_t                state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [15:0]           gap_q, gap_d;        // idle cycles still to spend in GAP
    logic [DATA_WIDTH-1:0] data_q, data_d;      // tdata of the beat being offered
    logic [31:0]           count_q, count_d;    // burst length latched at start
    logic [31:0]           beats_q, beats_d;    // handshakes completed this burst

    logic [15:0]           lfsr_step;
    logic [15:0]           gap_draw;
    logic [31:0]           beats_inc;

    // One LFSR step and the gap it yields; only consumed when a draw happens.
    assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign gap_draw  = lfsr_q % GAP_MOD;
    assign beats_inc = beats_q + 32'd1;

    // Next-state logic: burst sequencing, gap draws and beat accounting.
    always_comb begin
        // NOTE: every signal written here gets its hold value first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        lfsr_d  = lfsr_q;
        gap_d   = gap_q;
        data_d  = data_q;
        count_d = count_q;
        beats_d = beats_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    beats_d = '0;
                    if (num_beats_i != 32'd0) begin
                        count_d = num_beats_i;
                        data_d  = DATA_START;
                        lfsr_d  = lfsr_step;
                        gap_d   = gap_draw;
                        state_d = (gap_draw != 16'd0) ? S_GAP : S_SEND;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_GAP: begin
                if (gap_q <= 16'd1) begin
                    gap_d   = '0;
                    state_d = S_SEND;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end

            S_SEND: begin
                if (axis_m.tready) begin
                    beats_d = beats_inc;
                    data_d  = data_q + DATA_WIDTH'(1);
                    if (beats_inc == count_q) begin
                        state_d = S_DONE;
                    end else begin
                        lfsr_d  = lfsr_step;
                        gap_d   = gap_draw;
                        state_d = (gap_draw != 16'd0) ? S_GAP : S_SEND;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            gap_q   <= '0;
            data_q  <= DATA_START;
            count_q <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            count_q <= count_d;
            beats_q <= beats_d;
        end
    end

    // Outputs decode registered state only, so tvalid never depends on tready.
    assign axis_m.tvalid = (state_q == S_SEND);
    assign axis_m.tdata  = (state_q == S_SEND) ? data_q : '0;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign beats_sent_o  = beats_q;

endmodule

// File: tb/tb_axis_gap_source.sv
// Self-checking bench for axis_gap_source: three parameterisations driven by
// one directed sequence, with queued expected data and gaps compared on output.
module tb_axis_gap_source;

    localparam logic [15:0] SEED = 16'hACE1;

    logic clk;
    logic rst_n;
    logic rst_b_n;
    logic rst1_n;

    int n_tests = 0;
    int n_fail  = 0;

    // u0: back-to-back; u1: defaults; u2: 8-bit wrap test.
    logic        start0, start1, start2;
    logic [31:0] num0, num1, num2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [31:0] beats0, beats1, beats2;

    axi_stream_simple_if #(.DATA_WIDTH(32)) if0 ();
    axi_stream_simple_if #(.DATA_WIDTH(32)) if1 ();
    axi_stream_simple_if #(.DATA_WIDTH(8))  if2 ();

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [7:0]  q2[$];
    int          qg1[$];
    logic [15:0] m1;

    assign rst1_n = rst_n & rst_b_n;

    axis_gap_source #(.DATA_WIDTH(32), .MAX_GAP_CYCLES(0)) u0 (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(start0), .num_beats_i(num0),
        .busy_o(busy0), .done_o(done0), .beats_sent_o(beats0), .axis_m(if0)
    );

    axis_gap_source u1 (
        .clock_i(clk), .reset_n_i(rst1_n), .start_i(start1), .num_beats_i(num1),
        .busy_o(busy1), .done_o(done1), .beats_sent_o(beats1), .axis_m(if1)
    );

    axis_gap_source #(.DATA_WIDTH(8), .DATA_START(8'hFE)) u2 (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(start2), .num_beats_i(num2),
        .busy_o(busy2), .done_o(done2), .beats_sent_o(beats2), .axis_m(if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & 16'hB400)};
    endfunction

    // Queue data 0..n-1 and the n gaps the reference LFSR will draw for u1.
    task automatic push_burst1(input int n);
        for (int i = 0; i < n; i++) begin
            q1.push_back(32'(i));
            qg1.push_back(int'(m1 % 16'd11));
            m1 = lfsr_next(m1);
        end
    endtask

    // u0 data monitor.
    initial begin : mon0
        forever begin
            @(negedge clk);
            if (rst_n && if0.tvalid && if0.tready) begin
                check("u0_beat_expected", 64'(q0.size() != 0), 64'd1);
                if (q0.size() != 0) check("u0_tdata", 64'(if0.tdata), 64'(q0.pop_front()));
            end
        end
    end

    // u1 data and idle-gap monitor.
    initial begin : mon1
        int idle;
        bit fresh;
        idle  = 0;
        fresh = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst1_n) begin
                idle  = 0;
                fresh = 1'b0;
            end else begin
                if (start1 && !busy1) begin
                    idle  = 0;
                    fresh = 1'b1;
                end else if (!if1.tvalid) begin
                    idle++;
                end
                if (if1.tvalid && fresh) begin
                    fresh = 1'b0;
                    check("u1_gap_expected", 64'(qg1.size() != 0), 64'd1);
                    if (qg1.size() != 0) check("u1_gap", 64'(idle), 64'(qg1.pop_front()));
                end
                if (if1.tvalid && if1.tready) begin
                    check("u1_beat_expected", 64'(q1.size() != 0), 64'd1);
                    if (q1.size() != 0) check("u1_tdata", 64'(if1.tdata), 64'(q1.pop_front()));
                    idle  = 0;
                    fresh = 1'b1;
                end
            end
        end
    end

    // u2 data monitor.
    initial begin : mon2
        forever begin
            @(negedge clk);
            if (rst_n && if2.tvalid && if2.tready) begin
                check("u2_beat_expected", 64'(q2.size() != 0), 64'd1);
                if (q2.size() != 0) check("u2_tdata", 64'(if2.tdata), 64'(q2.pop_front()));
            end
        end
    end

    // Watchdog: the directed sequence bounds its own waits; this is a last resort.
    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        rst_n   = 1'b0;
        rst_b_n = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        num0 = '0; num1 = '0; num2 = '0;
        if0.tready = 1'b1; if1.tready = 1'b1; if2.tready = 1'b1;
        m1 = SEED;

        // Reset state.
        #12;
        check("rst_tvalid0", 64'(if0.tvalid), 64'd0);
        check("rst_tdata0",  64'(if0.tdata),  64'd0);
        check("rst_busy0",   64'(busy0),      64'd0);
        check("rst_done0",   64'(done0),      64'd0);
        check("rst_beats0",  64'(beats0),     64'd0);
        check("rst_tdata2",  64'(if2.tdata),  64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Back-to-back burst of 4 with no gaps.
        #1 start0 = 1'b1; num0 = 32'd4;
        for (int i = 0; i < 4; i++) q0.push_back(32'(i));
        @(posedge clk); #1 start0 = 1'b0; num0 = 32'd77;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("r030_tvalid", 64'(if0.tvalid), 64'd1);
        end
        @(negedge clk);
        check("r030_done",   64'(done0),      64'd1);
        check("r030_tvalid_off", 64'(if0.tvalid), 64'd0);
        check("r030_beats",  64'(beats0),     64'd4);
        @(negedge clk);
        check("r030_done_pulse", 64'(done0),  64'd0);
        check("r030_idle",   64'(busy0),      64'd0);

        // Zero-length burst, plus a start request while busy.
        @(posedge clk); #1 start1 = 1'b1; num1 = 32'd0;
        @(posedge clk); #1 start1 = 1'b0;
        @(negedge clk);
        check("r033_busy",   64'(busy1),      64'd1);
        check("r033_done",   64'(done1),      64'd1);
        check("r033_tvalid", 64'(if1.tvalid), 64'd0);
        start1 = 1'b1; num1 = 32'd5;
        @(posedge clk); #1 start1 = 1'b0;
        @(negedge clk);
        check("r033_busy_off", 64'(busy1), 64'd0);
        check("r033_done_off", 64'(done1), 64'd0);
        @(negedge clk);
        check("r033_ignored",  64'(busy1), 64'd0);

        // 100 beats with randomly toggled tready.
        @(posedge clk); #1 start1 = 1'b1; num1 = 32'd100;
        push_burst1(100);
        @(posedge clk); #1 start1 = 1'b0; num1 = 32'd3;
        for (k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (done1) break;
            @(posedge clk);
            #1 if1.tready = 1'($urandom_range(0, 1));
        end
        check("r031_done",  64'(done1),      64'd1);
        check("r031_beats", 64'(beats1),     64'd100);
        check("r031_drain", 64'(q1.size() + qg1.size()), 64'd0);

        // Single beat stalled by tready=0 for 50 cycles.
        @(posedge clk); #1 if1.tready = 1'b0; start1 = 1'b1; num1 = 32'd1;
        push_burst1(1);
        @(posedge clk); #1 start1 = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if1.tvalid) break;
        end
        check("r032_valid_seen", 64'(if1.tvalid), 64'd1);
        for (int i = 0; i < 50; i++) begin
            check("r032_hold_valid", 64'(if1.tvalid), 64'd1);
            check("r032_hold_data",  64'(if1.tdata),  64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 if1.tready = 1'b1;
        @(negedge clk);
        check("r032_offered", 64'(if1.tvalid), 64'd1);
        @(negedge clk);
        check("r032_done",  64'(done1),  64'd1);
        check("r032_beats", 64'(beats1), 64'd1);

        // Reset mid-burst after beat 5 of 10, then replay from the seed.
        @(posedge clk); #1 start1 = 1'b1; num1 = 32'd10;
        push_burst1(10);
        @(posedge clk); #1 start1 = 1'b0;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (beats1 == 32'd5) break;
        end
        check("r035_reached5", 64'(beats1), 64'd5);
        #2 rst_b_n = 1'b0;
        #1;
        check("r035_tvalid", 64'(if1.tvalid), 64'd0);
        check("r035_tdata",  64'(if1.tdata),  64'd0);
        check("r035_busy",   64'(busy1),      64'd0);
        check("r035_done",   64'(done1),      64'd0);
        check("r035_beats",  64'(beats1),     64'd0);
        q1.delete();
        qg1.delete();
        m1 = SEED;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_b_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("r035_no_done", 64'(done1), 64'd0);
        end
        @(posedge clk); #1 start1 = 1'b1; num1 = 32'd10;
        push_burst1(10);
        @(posedge clk); #1 start1 = 1'b0;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done1) break;
        end
        check("r035_replay_done",  64'(done1),  64'd1);
        check("r035_replay_beats", 64'(beats1), 64'd10);
        check("r035_replay_drain", 64'(q1.size() + qg1.size()), 64'd0);

        // 8-bit data counter wrapping from FE.
        @(posedge clk); #1 start2 = 1'b1; num2 = 32'd3;
        q2.push_back(8'hFE); q2.push_back(8'hFF); q2.push_back(8'h00);
        @(posedge clk); #1 start2 = 1'b0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done2) break;
        end
        check("r034_done",  64'(done2),     64'd1);
        check("r034_beats", 64'(beats2),    64'd3);
        check("r034_drain", 64'(q2.size()), 64'd0);
        check("r030_drain", 64'(q0.size()), 64'd0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
